// File: rtl/dsm_cic_decimator.sv
// CIC decimator recovering signed PCM samples from a 1-bit delta-sigma bitstream.
// Integrators run on each valid bit; the comb and output stages follow in the next two cycles.
module dsm_cic_decimator #(
    parameter int ORDER  = 3,
    parameter int LOG2_R = 5,
    parameter int OUT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic             i_in_bit,
    output logic             o_out_valid,
    output logic [OUT_W-1:0] o_out_sample,
    output logic             o_sat
);
    localparam int ACC_W  = ORDER * LOG2_R + 2;
    localparam int SHIFT  = ORDER * LOG2_R - (OUT_W - 1);
    localparam int Y_W    = OUT_W + 1;
    localparam int WARM_W = $clog2(ORDER + 1);

    generate
        if (ORDER < 1 || ORDER > 4) begin : g_bad_order
            $error("dsm_cic_decimator: ORDER must be 1..4");
        end
        if (LOG2_R < 1 || LOG2_R > 8) begin : g_bad_ratio
            $error("dsm_cic_decimator: LOG2_R must be 1..8");
        end
        if (SHIFT < 0) begin : g_bad_shift
            $error("dsm_cic_decimator: OUT_W too wide for ORDER*LOG2_R");
        end
    endgenerate

    logic [ORDER-1:0][ACC_W-1:0] r_integ;
    logic [ORDER-1:0][ACC_W-1:0] r_dly;
    logic [ORDER:0][ACC_W-1:0]   w_comb;
    logic [LOG2_R-1:0]           r_phase;
    logic [WARM_W-1:0]           r_warm;
    logic signed [ACC_W-1:0]     r_comb;
    logic                        r_comb_vld;
    logic                        r_dec_d;
    logic [ACC_W-1:0]            w_x;
    logic                        w_dec;
    logic signed [Y_W-1:0]       w_y;
    logic                        w_clip;
    logic [OUT_W-1:0]            w_y_sat;

    // +1 / -1 mapping without an adder: low bit always set, upper bits copy ~bit
    assign w_x   = {{(ACC_W-1){~i_in_bit}}, 1'b1};
    assign w_dec = i_in_valid && (r_phase == '1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_integ <= '0;
            r_phase <= '0;
            r_dec_d <= 1'b0;
        end else begin
            r_dec_d <= w_dec;
            if (i_in_valid) begin
                r_phase    <= r_phase + 1'b1;
                r_integ[0] <= r_integ[0] + w_x;
                for (int k = 1; k < ORDER; k++) begin
                    r_integ[k] <= r_integ[k] + r_integ[k-1];
                end
            end
        end
    end

    always_comb begin
        w_comb    = '0;
        w_comb[0] = r_integ[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            w_comb[k+1] = w_comb[k] - r_dly[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dly      <= '0;
            r_comb     <= '0;
            r_comb_vld <= 1'b0;
        end else begin
            r_comb_vld <= r_dec_d;
            if (r_dec_d) begin
                for (int k = 0; k < ORDER; k++) begin
                    r_dly[k] <= w_comb[k];
                end
                r_comb <= w_comb[ORDER];
            end
        end
    end

    // After the shift the value has exactly one guard bit above OUT_W
    assign w_y     = Y_W'(r_comb >>> SHIFT);
    assign w_clip  = w_y[OUT_W] ^ w_y[OUT_W-1];
    assign w_y_sat = w_y[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_warm       <= '0;
            o_out_valid  <= 1'b0;
            o_out_sample <= '0;
            o_sat        <= 1'b0;
        end else begin
            o_out_valid <= 1'b0;
            if (r_comb_vld) begin
                if (r_warm != WARM_W'(ORDER)) begin
                    r_warm <= r_warm + 1'b1;
                end else begin
                    o_out_valid  <= 1'b1;
                    o_out_sample <= w_clip ? w_y_sat : w_y[OUT_W-1:0];
                    if (w_clip) begin
                        o_sat <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
